// File: rtl/i2s_drain_ctrl.sv
// Drains audio samples from a FIFO into a ready/valid stream in fixed-length bursts.
// Optional two-sample 16-bit packing is built only when I2S_DRAIN_PACK16_EN is defined.
module i2s_drain_ctrl #(
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               pack16,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [4:0]         fifo_level,
    input  logic [31:0]        fifo_rdata,
    output logic               fifo_rd,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [31:0]        m_data,
    output logic               m_last,
    output logic               burst_done,
    output logic               ovf,
    input  logic               ovf_clr
);

    typedef enum logic [1:0] {IDLE, WAIT, READ, SEND} state_t;

    localparam logic [BURST_W:0] ONE        = 1;
    localparam logic [BURST_W:0] FULL_BURST = {1'b1, {BURST_W{1'b0}}};

    state_t             state;
    logic [BURST_W:0]   words_left;
    logic [BURST_W:0]   total;
    logic [5:0]         need;
    logic [5:0]         avail;
    logic               pack_in;

`ifdef I2S_DRAIN_PACK16_EN
    logic               pack_q;
    logic               half_q;
    logic [15:0]        first_q;
    assign pack_in = pack16;
`else
    logic               unused_pack;
    assign unused_pack = pack16;
    assign pack_in     = 1'b0;
`endif

    assign need  = 6'(burst_len) << pack_in;
    assign avail = fifo_full ? 6'd32 : {1'b0, fifo_level};
    // A zero length encodes the largest burst; the extra counter bit keeps it from wrapping.
    assign total = (burst_len == '0) ? FULL_BURST : {1'b0, burst_len};

    assign fifo_rd    = (state == READ) && !fifo_empty;
    assign burst_done = m_valid && m_ready && m_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            words_left <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            ovf        <= 1'b0;
`ifdef I2S_DRAIN_PACK16_EN
            pack_q     <= 1'b0;
            half_q     <= 1'b0;
            first_q    <= '0;
`endif
        end else begin
            // Overflow set takes priority over a simultaneous clear.
            if (fifo_full)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (en)
                        state <= WAIT;
                end
                WAIT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (avail >= need) begin
                        state      <= READ;
                        words_left <= total;
`ifdef I2S_DRAIN_PACK16_EN
                        pack_q     <= pack16;
                        half_q     <= 1'b0;
`endif
                    end
                end
                READ: begin
                    if (!fifo_empty) begin
`ifdef I2S_DRAIN_PACK16_EN
                        if (pack_q && !half_q) begin
                            first_q <= fifo_rdata[15:0];
                            half_q  <= 1'b1;
                        end else begin
                            m_data  <= pack_q ? {fifo_rdata[15:0], first_q} : fifo_rdata;
                            half_q  <= 1'b0;
                            m_valid <= 1'b1;
                            m_last  <= (words_left == ONE);
                            state   <= SEND;
                        end
`else
                        m_data  <= fifo_rdata;
                        m_valid <= 1'b1;
                        m_last  <= (words_left == ONE);
                        state   <= SEND;
`endif
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        m_valid    <= 1'b0;
                        m_last     <= 1'b0;
                        words_left <= words_left - ONE;
                        if (words_left == ONE)
                            state <= en ? WAIT : IDLE;
                        else
                            state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_drain_ctrl.sv
// Directed bench for i2s_drain_ctrl: bursts, packing, stalls, level gating, overflow and reset.
`timescale 1ns/1ps
module tb_i2s_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  burst_len;
  logic        pack16;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_level;
  logic [31:0] fifo_rdata;
  logic        fifo_rd;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        burst_done;
  logic        ovf;
  logic        ovf_clr;

  int errors = 0;
  int checks = 0;

  // FIFO model and handshake monitor
  logic [31:0] mem [0:31];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  logic        lvl_en = 1'b0;
  logic [4:0]  lvl    = 5'd0;
  int          n      = 0;
  int          cyc    = 0;
  logic [31:0] got_data [0:63];
  logic        got_last [0:63];
  logic        got_done [0:63];
  int          got_cyc  [0:63];

  int base;
  int rd0;
  int cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr[4:0]];
  assign fifo_level = lvl_en ? lvl : 5'(wr_ptr - rd_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      rd_ptr <= rd_ptr + 1;
      rd_cnt <= rd_cnt + 1;
    end
    if (m_valid && m_ready && n < 64) begin
      got_data[n] <= m_data;
      got_last[n] <= m_last;
      got_done[n] <= burst_done;
      got_cyc[n]  <= cyc;
      n <= n + 1;
    end
  end

  i2s_drain_ctrl #(.BURST_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .burst_len  (burst_len),
    .pack16     (pack16),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .burst_done (burst_done),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[4:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_words(input int want);
    cnt = 0;
    while ((n - base) < want && cnt < 200) begin
      step(1);
      cnt++;
    end
    checks++;
    if ((n - base) < want) begin
      errors++;
      $error("FAIL wait_words timeout: got %0d of %0d words", n - base, want);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; burst_len = 4'd0; pack16 = 1'b0;
    fifo_full = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
    step(3);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    step(2);

    // Four-word burst, no packing
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
    base = n; rd0 = rd_cnt;
    burst_len = 4'd4; en = 1'b1;
    wait_words(4);
    chk("t1_words", n - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", got_data[base+i], 32'(i + 1));
      chk("t1_last", got_last[base+i], (i == 3));
      chk("t1_done", got_done[base+i], (i == 3));
    end
    chk("t1_rd_pulses", rd_cnt - rd0, 4);
    chk("t1_spacing", got_cyc[base+1] - got_cyc[base], 2);
    en = 1'b0;
    step(2);

    // Packing request: honoured only when the feature is built in
    base = n; rd0 = rd_cnt;
    burst_len = 4'd2; pack16 = 1'b1;
`ifdef I2S_DRAIN_PACK16_EN
    push(32'h0000AAAA); push(32'h0000BBBB); push(32'h0000CCCC); push(32'h0000DDDD);
    en = 1'b1;
    wait_words(2);
    chk("t2_words", n - base, 2);
    chk("t2_word0", got_data[base], 32'hBBBBAAAA);
    chk("t2_word1", got_data[base+1], 32'hDDDDCCCC);
    chk("t2_last", got_last[base+1], 1'b1);
    chk("t2_rd_pulses", rd_cnt - rd0, 4);
    chk("t2_spacing", got_cyc[base+1] - got_cyc[base], 3);
`else
    push(32'h0000AAAA); push(32'h0000BBBB);
    en = 1'b1;
    wait_words(2);
    chk("t2_words", n - base, 2);
    chk("t2_word0", got_data[base], 32'h0000AAAA);
    chk("t2_word1", got_data[base+1], 32'h0000BBBB);
    chk("t2_last", got_last[base+1], 1'b1);
    chk("t2_rd_pulses", rd_cnt - rd0, 2);
    chk("t2_spacing", got_cyc[base+1] - got_cyc[base], 2);
`endif
    en = 1'b0; pack16 = 1'b0;
    step(2);

    // Level gating in WAIT, then a downstream stall
    push(32'd5); push(32'd6); push(32'd7); push(32'd8);
    base = n; rd0 = rd_cnt;
    lvl_en = 1'b1; lvl = 5'd3; burst_len = 4'd4; en = 1'b1;
    step(4);
    chk("t3_wait_rd", fifo_rd, 1'b0);
    chk("t3_wait_rd_cnt", rd_cnt - rd0, 0);
    lvl = 5'd4; m_ready = 1'b0;
    step(1);
    chk("t3_read_entered", fifo_rd, 1'b1);
    step(1);
    chk("t3_send_valid", m_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_stall_valid", m_valid, 1'b1);
      chk("t3_stall_data", m_data, 32'd5);
      chk("t3_stall_rd", fifo_rd, 1'b0);
    end
    m_ready = 1'b1; lvl_en = 1'b0;
    wait_words(4);
    chk("t3_words", n - base, 4);
    chk("t3_word0", got_data[base], 32'd5);
    chk("t3_word3", got_data[base+3], 32'd8);
    chk("t3_last", got_last[base+3], 1'b1);
    en = 1'b0;
    step(2);

    // Zero length means sixteen words; fifo_full supplies the availability
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    base = n;
    fifo_full = 1'b1; burst_len = 4'd0; en = 1'b1;
    wait_words(16);
    en = 1'b0;
    chk("t4_words", n - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_data", got_data[base+i], 32'h100 + 32'(i));
      chk("t4_last", got_last[base+i], (i == 15));
    end
    chk("t4_done", got_done[base+15], 1'b1);
    chk("t4_ovf_set", ovf, 1'b1);
    ovf_clr = 1'b1;
    step(2);
    chk("ovf_set_wins", ovf, 1'b1);
    fifo_full = 1'b0;
    step(1);
    chk("ovf_cleared", ovf, 1'b0);
    ovf_clr = 1'b0;
    step(2);

    // Reset in the middle of a burst
    push(32'd9); push(32'd10); push(32'd11); push(32'd12);
    base = n;
    fifo_full = 1'b1;
    step(1);
    fifo_full = 1'b0;
    burst_len = 4'd4; en = 1'b1;
    wait_words(2);
    chk("t5_words", n - base, 2);
    chk("t5_pre_ovf", ovf, 1'b1);
    chk("t5_pre_data", m_data, 32'd10);
    rst = 1'b1;
    #1;
    chk("t5_rst_fifo_rd", fifo_rd, 1'b0);
    chk("t5_rst_m_valid", m_valid, 1'b0);
    chk("t5_rst_m_data", m_data, 32'h0);
    chk("t5_rst_m_last", m_last, 1'b0);
    chk("t5_rst_burst_done", burst_done, 1'b0);
    chk("t5_rst_ovf", ovf, 1'b0);
    en = 1'b0;
    wr_ptr = rd_ptr;
    step(1);
    rst = 1'b0;
    base = n;
    step(5);
    chk("t5_no_words_after", n - base, 0);
    chk("t5_idle_valid", m_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
